// File: rtl/evt_encoder_pkg.sv
// Shared types and helpers for the event encoder.
package evt_encoder_pkg;

    localparam int MAX_N = 64;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // OR of set-bit positions; exact for a one-hot (or zero) vector.
    function automatic int oh2idx(input logic [MAX_N-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < MAX_N; i++)
            if (oh[i]) r = r | i;
        return r;
    endfunction

endpackage

// File: rtl/prio_rotate_sel.sv
// First-set-bit search over req, beginning at start and wrapping modulo N.
module prio_rotate_sel
    import evt_encoder_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter bit DESC  = 1'b0
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] grant;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            int pos;
            if (DESC) begin
                pos = int'(start) - i;
                if (pos < 0) pos = pos + N;
            end else begin
                pos = int'(start) + i;
                if (pos >= N) pos = pos - N;
            end
            if (req[pos] && !any) begin
                grant[pos] = 1'b1;
                any        = 1'b1;
            end
        end
    end

    assign idx = IDX_W'(oh2idx(MAX_N'(grant)));

endmodule

// File: rtl/evt_encoder.sv
// Latches event pulses and hands out one pending channel index per cycle.
module evt_encoder
    import evt_encoder_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDX_W   = $clog2(N),
    parameter int RR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N-1:0]     evt_in,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state, state_n;
    logic [N-1:0]     pend_q, pend_n, load_oh;
    logic [IDX_W-1:0] idx_q, rr_last, start, sel;
    logic             sel_any, load, ovf_q;

    // Fixed priority searches downward from the top channel.
    assign start = (RR_MODE != 0)
                 ? ((rr_last == LAST) ? '0 : rr_last + 1'b1)
                 : LAST;

    prio_rotate_sel #(
        .N     (N),
        .IDX_W (IDX_W),
        .DESC  (RR_MODE == 0)
    ) u_sel (
        .req   (pend_q & mask),
        .start (start),
        .any   (sel_any),
        .idx   (sel)
    );

    always_comb begin
        load    = sel_any && ((state == IDLE) || out_ready);
        load_oh = load ? (N'(1) << sel) : '0;
        pend_n  = (pend_q & ~load_oh) | evt_in;
        state_n = state;
        unique case (state)
            IDLE:    if (sel_any) state_n = PRESENT;
            PRESENT: if (out_ready && !sel_any) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            rr_last <= LAST;
        end else if (clr) begin
            state   <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            rr_last <= LAST;
        end else begin
            state  <= state_n;
            pend_q <= pend_n;
            ovf_q  <= |(evt_in & pend_q & ~load_oh);
            if (load) begin
                idx_q   <= sel;
                rr_last <= sel;
            end
        end
    end

    assign out_valid = (state == PRESENT);
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_evt_encoder.sv
// Directed bench for evt_encoder: fixed-priority and round-robin instances.
module tb_evt_encoder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr, rdy;
    logic [N-1:0] evt, msk;

    logic [1:0]        v, ov;
    logic [1:0][1:0]   ix;
    logic [1:0][N-1:0] pd;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    evt_encoder #(.N(N), .RR_MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .evt_in(evt), .mask(msk),
        .out_valid(v[0]), .out_ready(rdy), .out_idx(ix[0]),
        .pending(pd[0]), .overflow(ov[0])
    );

    evt_encoder #(.N(N), .RR_MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .evt_in(evt), .mask(msk),
        .out_valid(v[1]), .out_ready(rdy), .out_idx(ix[1]),
        .pending(pd[1]), .overflow(ov[1])
    );

    // Reference model, one slot per instance (0 = fixed, 1 = round-robin).
    logic [N-1:0] mp[2];
    logic         mv[2];
    logic         mo[2];
    int           mi[2];
    int           ml[2];

    function automatic int pick(int m);
        logic [N-1:0] e = mp[m] & msk;
        if (m == 0) begin
            for (int i = N - 1; i >= 0; i--)
                if (e[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ml[m] + k) % N;
                if (e[c]) return c;
            end
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ldoh(int m);
        int s;
        s = pick(m);
        if (s >= 0 && (!mv[m] || rdy)) return N'(1) << s;
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n || clr) begin
                mp[m] <= '0;
                mv[m] <= 1'b0;
                mo[m] <= 1'b0;
                mi[m] <= 0;
                ml[m] <= N - 1;
            end else begin
                mo[m] <= |(evt & mp[m] & ~ldoh(m));
                mp[m] <= (mp[m] & ~ldoh(m)) | evt;
                if (ldoh(m) != '0) begin
                    mv[m] <= 1'b1;
                    mi[m] <= pick(m);
                    ml[m] <= pick(m);
                end else if (mv[m] && rdy) begin
                    mv[m] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int m,
                       input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[d%0d] t=%0t: got %0d want %0d",
                     nm, m, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("m_valid", m, int'(v[m]), int'(mv[m]));
            chk("m_pend", m, int'(pd[m]), int'(mp[m]));
            chk("m_ovf", m, int'(ov[m]), int'(mo[m]));
            if (mv[m]) chk("m_idx", m, int'(ix[m]), mi[m]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        evt = '0;
        msk = 4'b1111;
        rdy = 1'b1;
        clr = 1'b0;
        tick();
        tick();
        chk("rst_valid", 0, int'(v[0]), 0);
        chk("rst_idx", 0, int'(ix[0]), 0);
        chk("rst_pend", 0, int'(pd[0]), 0);
        chk("rst_ovf", 1, int'(ov[1]), 0);
        rst_n = 1'b1;
        tick();

        // single event, two-edge latency, one-cycle presentation
        evt = 4'b0001;
        tick();
        evt = '0;
        chk("t1_pend", 0, int'(pd[0]), 1);
        chk("t1_v0", 0, int'(v[0]), 0);
        tick();
        chk("t1_v1", 0, int'(v[0]), 1);
        chk("t1_idx", 0, int'(ix[0]), 0);
        chk("t1_pend2", 0, int'(pd[0]), 0);
        tick();
        chk("t1_v2", 0, int'(v[0]), 0);

        // burst drains highest first
        evt = 4'b1111;
        tick();
        evt = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_idx", 0, int'(ix[0]), 3 - i);
            chk("t2_v", 0, int'(v[0]), 1);
            chk("t2_ovf", 0, int'(ov[0]), 0);
        end
        tick();
        chk("t2_end", 0, int'(v[0]), 0);

        // backpressure
        rdy = 1'b0;
        evt = 4'b0010;
        tick();
        evt = '0;
        tick();
        tick();
        evt = 4'b1000;
        tick();
        evt = '0;
        chk("t3_idx", 0, int'(ix[0]), 1);
        chk("t3_pend", 0, int'(pd[0]), 8);
        tick();
        chk("t3_hold", 0, int'(ix[0]), 1);
        rdy = 1'b1;
        tick();
        chk("t3_next", 0, int'(ix[0]), 3);
        chk("t3_nv", 0, int'(v[0]), 1);
        tick();
        chk("t3_end", 0, int'(v[0]), 0);

        // overflow on a channel already pending
        rdy = 1'b0;
        evt = 4'b0100;
        tick();
        evt = '0;
        tick();
        tick();
        evt = 4'b0100;
        tick();
        evt = '0;
        chk("t4_pend", 0, int'(pd[0]), 4);
        chk("t4_noovf", 0, int'(ov[0]), 0);
        tick();
        tick();
        evt = 4'b0100;
        tick();
        evt = '0;
        chk("t4_ovf", 0, int'(ov[0]), 1);
        chk("t4_pend2", 0, int'(pd[0]), 4);
        tick();
        chk("t4_ovf_end", 0, int'(ov[0]), 0);
        rdy = 1'b1;
        tick();
        chk("t4_idx", 0, int'(ix[0]), 2);
        tick();
        chk("t4_end", 0, int'(v[0]), 0);

        // round-robin with events held high
        clr = 1'b1;
        tick();
        clr = 1'b0;
        evt = 4'b1111;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_rr", 1, int'(ix[1]), i % 4);
        end
        evt = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        msk = 4'b0101;
        evt = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_rrm", 1, int'(ix[1]), (i % 2) * 2);
        end
        evt = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // mask selects one channel, then clr, then async reset
        rdy = 1'b0;
        msk = 4'b0100;
        evt = 4'b0110;
        tick();
        evt = '0;
        tick();
        chk("t6_idx", 0, int'(ix[0]), 2);
        chk("t6_pend", 0, int'(pd[0]), 2);
        chk("t6_idx_rr", 1, int'(ix[1]), 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_clr_v", 0, int'(v[0]), 0);
        chk("t6_clr_p", 0, int'(pd[0]), 0);
        evt = 4'b0110;
        tick();
        evt = '0;
        tick();
        chk("t6_v", 0, int'(v[0]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_v", 0, int'(v[0]), 0);
        chk("t6_rst_v", 1, int'(v[1]), 0);
        chk("t6_rst_p", 0, int'(pd[0]), 0);
        chk("t6_rst_i", 1, int'(ix[1]), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
